frame_swap_ctrl: RTL and testbench

FRAME_SWAP_CTRL -- requirements
Module: frame_swap_ctrl

---
 rtl/frame_swap_ctrl.sv | 93 +++++++++
 tb/tb_frame_swap_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_swap_ctrl.sv
// rtl/frame_swap_ctrl.sv - double-buffer swap sequencer: clear back buffer, hand off to renderer, swap on vblank
module frame_swap_ctrl #(
   parameter int WIDTH  = 4,
   parameter int HEIGHT = 4,
   parameter int CNT_W  = 8,
   localparam int PIX    = WIDTH * HEIGHT,
   localparam int ADDR_W = (PIX > 1) ? $clog2(PIX) : 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              enable,
   input  logic              vblank_start,
   input  logic              frame_done,
   output logic              disp_sel,
   output logic              draw_sel,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr,
   output logic              draw_go,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   typedef enum logic [1:0] {IDLE, CLEAR, DRAW, WAIT_VBL} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX - 1);

   state_t state, state_nxt;
   logic   swap;
   logic   miss;
   logic   clr_last;

   assign clr_last = (clr_addr == LAST_ADDR);
   assign clr_we   = (state == CLEAR);
   assign draw_sel = ~disp_sel;

   always_comb begin
      state_nxt = state;
      swap      = 1'b0;
      miss      = 1'b0;
      case (state)
         IDLE: begin
            if (enable) state_nxt = CLEAR;
         end
         CLEAR: begin
            if (vblank_start) miss = 1'b1;
            if (clr_last) state_nxt = DRAW;
         end
         DRAW: begin
            if (frame_done && vblank_start) begin
               swap      = 1'b1;
               state_nxt = CLEAR;
            end else if (frame_done) begin
               state_nxt = WAIT_VBL;
            end else if (vblank_start) begin
               miss = 1'b1;
            end
         end
         WAIT_VBL: begin
            if (vblank_start) begin
               swap      = 1'b1;
               state_nxt = CLEAR;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // clr_addr sits at 0 outside CLEAR so the next CLEAR always starts from pixel 0
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         disp_sel  <= 1'b0;
         clr_addr  <= '0;
         draw_go   <= 1'b0;
         frame_cnt <= '0;
         miss_cnt  <= '0;
      end else begin
         state   <= state_nxt;
         draw_go <= (state == CLEAR) && clr_last;
         if (state == CLEAR && !clr_last)
            clr_addr <= clr_addr + ADDR_W'(1);
         else
            clr_addr <= '0;
         if (swap) begin
            disp_sel  <= ~disp_sel;
            frame_cnt <= frame_cnt + CNT_W'(1);
         end
         if (miss && miss_cnt != {CNT_W{1'b1}})
            miss_cnt <= miss_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_frame_swap_ctrl.sv
// tb/tb_frame_swap_ctrl.sv - directed self-checking bench for frame_swap_ctrl
module tb_frame_swap_ctrl;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       enable = 1'b0;
   logic       vblank_start = 1'b0;
   logic       frame_done = 1'b0;
   logic       disp_sel, draw_sel, clr_we, draw_go;
   logic [3:0] clr_addr;
   logic [7:0] frame_cnt, miss_cnt;

   logic       s_disp_sel, s_draw_sel, s_clr_we, s_draw_go;
   logic [3:0] s_clr_addr;
   logic [1:0] s_frame_cnt, s_miss_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   frame_swap_ctrl #(.WIDTH(4), .HEIGHT(4), .CNT_W(8)) dut (
      .clk(clk), .resetn(resetn), .enable(enable), .vblank_start(vblank_start),
      .frame_done(frame_done), .disp_sel(disp_sel), .draw_sel(draw_sel),
      .clr_we(clr_we), .clr_addr(clr_addr), .draw_go(draw_go),
      .frame_cnt(frame_cnt), .miss_cnt(miss_cnt)
   );

   frame_swap_ctrl #(.WIDTH(4), .HEIGHT(4), .CNT_W(2)) dut_small (
      .clk(clk), .resetn(resetn), .enable(enable), .vblank_start(vblank_start),
      .frame_done(frame_done), .disp_sel(s_disp_sel), .draw_sel(s_draw_sel),
      .clr_we(s_clr_we), .clr_addr(s_clr_addr), .draw_go(s_draw_go),
      .frame_cnt(s_frame_cnt), .miss_cnt(s_miss_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // steps until draw_go, bounded so a stuck FSM cannot hang the run
   task automatic wait_draw();
      int n = 0;
      while (draw_go !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      checks++;
      if (draw_go !== 1'b1) begin
         errors++;
         $display("FAIL wait_draw_go: draw_go=%b after %0d cycles, required 1", draw_go, n);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      #1;
      checks++;
      if ({disp_sel, draw_sel, clr_we, clr_addr, draw_go, frame_cnt, miss_cnt} !== {1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 8'd0, 8'd0}) begin
         errors++;
         $display("FAIL reset_values: disp=%b draw=%b we=%b addr=%0d go=%b fc=%0d mc=%0d, required 0 1 0 0 0 0 0",
                  disp_sel, draw_sel, clr_we, clr_addr, draw_go, frame_cnt, miss_cnt);
      end
      step();
      step();
      checks++;
      if (clr_we !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold_we: clr_we=%b, required 0", clr_we);
      end
   endtask

   task automatic test_clear();
      resetn = 1'b1;
      step();
      vblank_start = 1'b1;
      frame_done = 1'b1;
      step();
      vblank_start = 1'b0;
      frame_done = 1'b0;
      checks++;
      if (clr_we !== 1'b0 || miss_cnt !== 8'd0) begin
         errors++;
         $display("FAIL idle_ignore: clr_we=%b miss=%0d, required 0 0", clr_we, miss_cnt);
      end
      enable = 1'b1;
      step();
      enable = 1'b0;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (clr_we !== 1'b1 || clr_addr !== 4'(i) || draw_sel !== 1'b1 || disp_sel !== 1'b0 || draw_go !== 1'b0) begin
            errors++;
            $display("FAIL clear_seq[%0d]: we=%b addr=%0d draw_sel=%b disp=%b go=%b, required 1 %0d 1 0 0",
                     i, clr_we, clr_addr, draw_sel, disp_sel, draw_go, i);
         end
         step();
      end
      checks++;
      if (draw_go !== 1'b1 || clr_we !== 1'b0 || clr_addr !== 4'd0 || disp_sel !== 1'b0) begin
         errors++;
         $display("FAIL draw_go_pulse: go=%b we=%b addr=%0d disp=%b, required 1 0 0 0", draw_go, clr_we, clr_addr, disp_sel);
      end
      step();
      checks++;
      if (draw_go !== 1'b0) begin
         errors++;
         $display("FAIL draw_go_single: draw_go=%b, required 0", draw_go);
      end
   endtask

   task automatic test_swap_after_wait();
      frame_done = 1'b1;
      step();
      frame_done = 1'b0;
      step();
      frame_done = 1'b1;
      step();
      frame_done = 1'b0;
      checks++;
      if (disp_sel !== 1'b0 || clr_we !== 1'b0 || frame_cnt !== 8'd0) begin
         errors++;
         $display("FAIL wait_vbl_hold: disp=%b we=%b fc=%0d, required 0 0 0", disp_sel, clr_we, frame_cnt);
      end
      vblank_start = 1'b1;
      step();
      vblank_start = 1'b0;
      checks++;
      if (disp_sel !== 1'b1 || draw_sel !== 1'b0 || frame_cnt !== 8'd1 || clr_we !== 1'b1 || clr_addr !== 4'd0 || miss_cnt !== 8'd0) begin
         errors++;
         $display("FAIL swap_wait: disp=%b draw=%b fc=%0d we=%b addr=%0d mc=%0d, required 1 0 1 1 0 0",
                  disp_sel, draw_sel, frame_cnt, clr_we, clr_addr, miss_cnt);
      end
      wait_draw();
   endtask

   task automatic test_same_cycle_swap();
      step();
      frame_done = 1'b1;
      vblank_start = 1'b1;
      step();
      frame_done = 1'b0;
      vblank_start = 1'b0;
      checks++;
      if (disp_sel !== 1'b0 || frame_cnt !== 8'd2 || miss_cnt !== 8'd0 || clr_we !== 1'b1) begin
         errors++;
         $display("FAIL swap_same_cycle: disp=%b fc=%0d mc=%0d we=%b, required 0 2 0 1", disp_sel, frame_cnt, miss_cnt, clr_we);
      end
      wait_draw();
   endtask

   task automatic test_miss();
      vblank_start = 1'b1;
      step();
      vblank_start = 1'b0;
      step();
      vblank_start = 1'b1;
      step();
      vblank_start = 1'b0;
      checks++;
      if (miss_cnt !== 8'd2 || disp_sel !== 1'b0 || frame_cnt !== 8'd2) begin
         errors++;
         $display("FAIL miss_draw: mc=%0d disp=%b fc=%0d, required 2 0 2", miss_cnt, disp_sel, frame_cnt);
      end
      frame_done = 1'b1;
      step();
      frame_done = 1'b0;
      vblank_start = 1'b1;
      step();
      checks++;
      if (disp_sel !== 1'b1 || frame_cnt !== 8'd3 || miss_cnt !== 8'd2) begin
         errors++;
         $display("FAIL swap_after_miss: disp=%b fc=%0d mc=%0d, required 1 3 2", disp_sel, frame_cnt, miss_cnt);
      end
      frame_done = 1'b1;
      step();
      frame_done = 1'b0;
      checks++;
      if (miss_cnt !== 8'd3 || disp_sel !== 1'b1 || clr_we !== 1'b1 || clr_addr !== 4'd1) begin
         errors++;
         $display("FAIL miss_clear: mc=%0d disp=%b we=%b addr=%0d, required 3 1 1 1", miss_cnt, disp_sel, clr_we, clr_addr);
      end
      step();
      step();
      vblank_start = 1'b0;
      checks++;
      if (miss_cnt !== 8'd5 || s_miss_cnt !== 2'd3) begin
         errors++;
         $display("FAIL miss_saturate: mc=%0d small_mc=%0d, required 5 3", miss_cnt, s_miss_cnt);
      end
      wait_draw();
   endtask

   task automatic test_reset_mid_clear();
      frame_done = 1'b1;
      vblank_start = 1'b1;
      step();
      frame_done = 1'b0;
      vblank_start = 1'b0;
      for (int i = 0; i < 7; i++) step();
      checks++;
      if (clr_addr !== 4'd7 || disp_sel !== 1'b0 || frame_cnt !== 8'd4) begin
         errors++;
         $display("FAIL pre_abort: addr=%0d disp=%b fc=%0d, required 7 0 4", clr_addr, disp_sel, frame_cnt);
      end
      resetn = 1'b0;
      #1;
      checks++;
      if ({disp_sel, draw_sel, clr_we, clr_addr, draw_go, frame_cnt, miss_cnt} !== {1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 8'd0, 8'd0}) begin
         errors++;
         $display("FAIL async_abort: disp=%b draw=%b we=%b addr=%0d go=%b fc=%0d mc=%0d, required 0 1 0 0 0 0 0",
                  disp_sel, draw_sel, clr_we, clr_addr, draw_go, frame_cnt, miss_cnt);
      end
      step();
      resetn = 1'b1;
      enable = 1'b1;
      step();
      enable = 1'b0;
      checks++;
      if (clr_we !== 1'b1 || clr_addr !== 4'd0 || draw_sel !== 1'b1) begin
         errors++;
         $display("FAIL restart_clear: we=%b addr=%0d draw_sel=%b, required 1 0 1", clr_we, clr_addr, draw_sel);
      end
      wait_draw();
   endtask

   task automatic test_frame_wrap();
      int   toggles = 0;
      logic prev;
      for (int k = 0; k < 256; k++) begin
         prev = disp_sel;
         frame_done = 1'b1;
         vblank_start = 1'b1;
         step();
         frame_done = 1'b0;
         vblank_start = 1'b0;
         if (disp_sel !== prev) toggles++;
         if (k == 254) begin
            checks++;
            if (frame_cnt !== 8'd255) begin
               errors++;
               $display("FAIL frame_cnt_255: fc=%0d, required 255", frame_cnt);
            end
         end
         wait_draw();
      end
      checks++;
      if (frame_cnt !== 8'd0 || disp_sel !== 1'b0 || toggles != 256) begin
         errors++;
         $display("FAIL frame_wrap: fc=%0d disp=%b toggles=%0d, required 0 0 256", frame_cnt, disp_sel, toggles);
      end
   endtask

   initial begin
      test_reset();
      test_clear();
      test_swap_after_wait();
      test_same_cycle_swap();
      test_miss();
      test_reset_mid_clear();
      test_frame_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
